// File: rtl/npc3l_multileg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : PKG_decoder_3lxnpc
// Purpose : Shared types and constants for the multi-leg 3-level NPC
//           commutation sequencer. Holds the leg-state and step enums, the
//           gate switch codes and small helpers that map a level onto its code.
// Revision: 1.0 - initial release
// ============================================================================
package PKG_decoder_3lxnpc;

    localparam int TW_DEFAULT = 8;

    // Encoding deliberately matches the v_lev request coding (0=Z, 1=P, 2=N).
    // Code 3 is only ever reached internally as the shut-down state.
    typedef enum logic [1:0] {
        LEG_Z   = 2'd0,
        LEG_P   = 2'd1,
        LEG_N   = 2'd2,
        LEG_OFF = 2'd3
    } leg_state_e;

    typedef enum logic [1:0] {
        STEP_IDLE = 2'd0,
        STEP_DEAD = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_SHUT = 2'd3
    } step_e;

    // Gate codes {S1,S2,S3,S4}
    localparam logic [3:0] SW_P          = 4'b1100;
    localparam logic [3:0] SW_Z          = 4'b0110;
    localparam logic [3:0] SW_N          = 4'b0011;
    localparam logic [3:0] SW_OFF        = 4'b0000;
    localparam logic [3:0] SW_DEAD_P     = 4'b0100;
    localparam logic [3:0] SW_DEAD_N     = 4'b0010;
    localparam logic [3:0] SW_INNER_MASK = 4'b0110;

    function automatic logic [3:0] stable_code(input leg_state_e lvl);
        logic [3:0] code;
        case (lvl)
            LEG_P:   code = SW_P;
            LEG_N:   code = SW_N;
            LEG_Z:   code = SW_Z;
            default: code = SW_OFF;
        endcase
        return code;
    endfunction

    // Every commutation segment touches Z; only the P side (S2 alone) or the
    // N side (S3 alone) stays on through the dead time.
    function automatic logic [3:0] dead_code(input leg_state_e from_lvl,
                                             input leg_state_e to_lvl);
        return ((from_lvl == LEG_P) || (to_lvl == LEG_P)) ? SW_DEAD_P : SW_DEAD_N;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc3l_leg_fsm.sv
`default_nettype none
// ============================================================================
// Module  : npc3l_leg_fsm
// Purpose : Commutation sequencer for one 3-level NPC leg. Walks Z<->P and
//           Z<->N transitions through a dead-time step and a minimum-hold
//           step, chains P<->N through Z, and performs the controlled
//           shutdown (outer switches off, inner held for dead time, then OFF).
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           t_dead_i/t_min_i - timing values, captured at sequence start
//           v_lev_i          - level request (0=Z 1=P 2=N 3=no-op)
//           fault_i          - abort request from the fault input
//           lock_i           - inhibits request sampling while fault latched
//           rearm_i          - single-cycle re-arm, OFF -> Z
//           s_o              - registered gate code {S1,S2,S3,S4}
//           busy_o           - high during dead/hold step cycles
//           off_o            - leg has completed shutdown and sits in OFF
// Revision: 1.0 - initial release
// ============================================================================
module npc3l_leg_fsm
    import PKG_decoder_3lxnpc::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] t_dead_i,
    input  logic [TW-1:0] t_min_i,
    input  logic [1:0]    v_lev_i,
    input  logic          fault_i,
    input  logic          lock_i,
    input  logic          rearm_i,
    output logic [3:0]    s_o,
    output logic          busy_o,
    output logic          off_o
);

    localparam logic [TW-1:0] ONE = TW'(1);

    // level_q : stable level the leg last settled in (origin of a sequence)
    // seg_to_q: destination of the segment being executed
    // final_q : destination of the whole (possibly chained) sequence
    leg_state_e    level_q,  level_d;
    leg_state_e    seg_to_q, seg_to_d;
    leg_state_e    final_q,  final_d;
    step_e         step_q,   step_d;
    logic [TW-1:0] cnt_q,    cnt_d;
    logic [TW-1:0] td_q,     td_d;
    logic [TW-1:0] tm_q,     tm_d;
    logic [3:0]    s_q,      s_d;

    logic [TW-1:0] w_td_eff;
    logic [TW-1:0] w_tm_eff;
    leg_state_e    w_req;
    leg_state_e    w_first_to;
    logic          w_abort;

    // Zero timing values are promoted to one cycle.
    assign w_td_eff = (t_dead_i == '0) ? ONE : t_dead_i;
    assign w_tm_eff = (t_min_i  == '0) ? ONE : t_min_i;
    assign w_req    = leg_state_e'(v_lev_i);

    // From Z the first segment goes straight to the target; from P or N the
    // first segment always returns to Z (P<->N continues from there).
    assign w_first_to = (level_q == LEG_Z) ? w_req : LEG_Z;

    // A leg already shutting down or already OFF is not restarted by a fault
    // that stays high.
    assign w_abort = fault_i && (step_q != STEP_SHUT) && (level_q != LEG_OFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= LEG_Z;
            seg_to_q <= LEG_Z;
            final_q  <= LEG_Z;
            step_q   <= STEP_IDLE;
            cnt_q    <= '0;
            td_q     <= '0;
            tm_q     <= '0;
            s_q      <= SW_Z;
        end else begin
            level_q  <= level_d;
            seg_to_q <= seg_to_d;
            final_q  <= final_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            td_q     <= td_d;
            tm_q     <= tm_d;
            s_q      <= s_d;
        end
    end

    always_comb begin
        level_d  = level_q;
        seg_to_d = seg_to_q;
        final_d  = final_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        td_d     = td_q;
        tm_d     = tm_q;
        s_d      = s_q;

        if (w_abort) begin
            // Outer switches open at once; inner ones stay for the dead time.
            step_d = STEP_SHUT;
            s_d    = s_q & SW_INNER_MASK;
            cnt_d  = w_td_eff - ONE;
        end else begin
            case (step_q)
                STEP_IDLE: begin
                    if (level_q == LEG_OFF) begin
                        if (rearm_i) begin
                            level_d = LEG_Z;
                            s_d     = SW_Z;
                        end
                    end else if (!lock_i && (v_lev_i != 2'd3) && (w_req != level_q)) begin
                        td_d     = w_td_eff;
                        tm_d     = w_tm_eff;
                        cnt_d    = w_td_eff - ONE;
                        final_d  = w_req;
                        seg_to_d = w_first_to;
                        step_d   = STEP_DEAD;
                        s_d      = dead_code(level_q, w_first_to);
                    end
                end
                STEP_DEAD: begin
                    if (cnt_q == '0) begin
                        step_d = STEP_HOLD;
                        cnt_d  = tm_q - ONE;
                        s_d    = stable_code(seg_to_q);
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                STEP_HOLD: begin
                    if (cnt_q == '0) begin
                        if (seg_to_q != final_q) begin
                            // Second half of P<->N: leave Z with no idle cycle.
                            level_d  = LEG_Z;
                            seg_to_d = final_q;
                            step_d   = STEP_DEAD;
                            cnt_d    = td_q - ONE;
                            s_d      = dead_code(LEG_Z, final_q);
                        end else begin
                            level_d = seg_to_q;
                            step_d  = STEP_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                STEP_SHUT: begin
                    if (cnt_q == '0) begin
                        level_d = LEG_OFF;
                        step_d  = STEP_IDLE;
                        s_d     = SW_OFF;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    step_d = STEP_IDLE;
                end
            endcase
        end
    end

    assign s_o    = s_q;
    assign busy_o = (step_q == STEP_DEAD) || (step_q == STEP_HOLD);
    assign off_o  = (level_q == LEG_OFF) && (step_q == STEP_IDLE);

endmodule
`default_nettype wire

// File: rtl/npc3l_multileg_seq.sv
`default_nettype none
// ============================================================================
// Module  : npc3l_multileg_seq
// Purpose : N_LEGS independent 3-level NPC leg sequencers sharing timing
//           inputs, plus the sticky fault latch and the re-arm handshake.
// Ports   : clk, rst       - clock, asynchronous active-high reset
//           t_dead, t_min  - shared dead-time / minimum-hold cycle counts
//           v_lev          - per-leg level request, leg i at [2i+1:2i]
//           fault          - level-sensitive shutdown request
//           fault_clr      - re-arm pulse, honoured only once all legs OFF
//           S_out          - gate codes, leg i at [4i+3:4i] = {S1,S2,S3,S4}
//           busy           - per-leg commutation-in-progress flags
//           fault_active   - fault latched, until re-arm completes
// Revision: 1.0 - initial release
// ============================================================================
module npc3l_multileg_seq
    import PKG_decoder_3lxnpc::*;
#(
    parameter int N_LEGS = 3,
    parameter int TW     = TW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TW-1:0]         t_dead,
    input  logic [TW-1:0]         t_min,
    input  logic [2*N_LEGS-1:0]   v_lev,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic [4*N_LEGS-1:0]   S_out,
    output logic [N_LEGS-1:0]     busy,
    output logic                  fault_active
);

    logic              fault_active_q, fault_active_d;
    logic              rearm_q;
    logic              w_rearm;
    logic [N_LEGS-1:0] w_off;

    // Re-arm needs the fault released, the latch set and every leg through
    // its shutdown dead-time; fault always wins over fault_clr.
    assign w_rearm = fault_clr && !fault && fault_active_q && (&w_off);

    // The latch drops one cycle after the legs were driven back to Z.
    always_comb begin
        fault_active_d = fault_active_q;
        if (fault) begin
            fault_active_d = 1'b1;
        end else if (rearm_q) begin
            fault_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_active_q <= 1'b0;
            rearm_q        <= 1'b0;
        end else begin
            fault_active_q <= fault_active_d;
            rearm_q        <= w_rearm;
        end
    end

    for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
        npc3l_leg_fsm #(
            .TW (TW)
        ) u_leg (
            .clk      (clk),
            .rst      (rst),
            .t_dead_i (t_dead),
            .t_min_i  (t_min),
            .v_lev_i  (v_lev[2*g +: 2]),
            .fault_i  (fault),
            .lock_i   (fault_active_q),
            .rearm_i  (w_rearm),
            .s_o      (S_out[4*g +: 4]),
            .busy_o   (busy[g]),
            .off_o    (w_off[g])
        );
    end

    assign fault_active = fault_active_q;

endmodule
`default_nettype wire
